spi_sequencer: RTL and testbench

SPI_SEQUENCER -- requirements
Module: spi_sequencer

---
 rtl/obi_spi_pkg.sv | 28 ++
 rtl/obi_single_master.sv | 75 +++++++
 rtl/spi_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_spi_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_spi_pkg.sv
// Shared register map, bit indices and sequencer state encoding for the
// OBI-attached SPI peripheral and the sequencer that drives it.
package obi_spi_pkg;

    localparam logic [31:0] REG_CTRL    = 32'h0000_0000;
    localparam logic [31:0] REG_STATUS  = 32'h0000_0004;
    localparam logic [31:0] REG_DATA_TX = 32'h0000_0008;
    localparam logic [31:0] REG_CLK_DIV = 32'h0000_000C;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_START_BIT = 1;
    localparam int CTRL_CPOL_BIT  = 2;
    localparam int CTRL_CPHA_BIT  = 3;
    localparam int STAT_BUSY_BIT  = 0;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_CS_SETUP,
        ST_WR_DATA,
        ST_WR_CTRL,
        ST_POLL_CTRL,
        ST_POLL_STAT,
        ST_CS_HOLD,
        ST_ERROR
    } seq_state_e;

endpackage

// File: rtl/obi_single_master.sv
// One OBI transaction at a time: request held stable until grant, then the
// response is passed through as a single-cycle done pulse.
module obi_single_master (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        obi_req_o,
    output logic        obi_we_o,
    output logic [31:0] obi_addr_o,
    output logic [31:0] obi_wdata_o,
    input  logic        obi_gnt_i,
    input  logic        obi_rvalid_i,
    input  logic [31:0] obi_rdata_i,
    input  logic        obi_err_i
);
    typedef enum logic [1:0] {M_IDLE, M_REQ, M_RESP} m_state_e;

    m_state_e    state_q, state_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= M_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            M_IDLE: if (start_i) begin
                req_d   = 1'b1;
                we_d    = we_i;
                addr_d  = addr_i;
                wdata_d = wdata_i;
                state_d = M_REQ;
            end
            M_REQ: if (obi_gnt_i) begin
                req_d   = 1'b0;
                state_d = M_RESP;
            end
            M_RESP: if (obi_rvalid_i) state_d = M_IDLE;
            default: state_d = M_IDLE;
        endcase
    end

    assign done_o      = (state_q == M_RESP) && obi_rvalid_i;
    assign err_o       = done_o && obi_err_i;
    assign rdata_o     = obi_rdata_i;
    assign obi_req_o   = req_q;
    assign obi_we_o    = we_q;
    assign obi_addr_o  = addr_q;
    assign obi_wdata_o = wdata_q;

endmodule

// File: rtl/spi_sequencer.sv
// Streams command bytes to an OBI SPI peripheral: programs CLK_DIV once, then
// per byte writes DATA_TX, kicks CTRL and polls until the shift completes.
module spi_sequencer
    import obi_spi_pkg::*;
#(
    parameter logic [31:0] SPI_BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]  CTRL_CFG      = 8'h01,
    parameter logic [7:0]  CLK_DIV       = 8'h01,
    parameter int          CS_SETUP      = 2,
    parameter int          CS_HOLD       = 2,
    parameter int          POLL_LIMIT    = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [7:0]  cmd_byte_i,
    input  logic        cmd_dc_i,
    input  logic        cmd_last_i,
    output logic        obi_req_o,
    output logic        obi_we_o,
    output logic [3:0]  obi_be_o,
    output logic [31:0] obi_addr_o,
    output logic [31:0] obi_wdata_o,
    input  logic        obi_gnt_i,
    input  logic        obi_rvalid_i,
    input  logic [31:0] obi_rdata_i,
    input  logic        obi_err_i,
    output logic        cs_no,
    output logic        dc_o,
    output logic        busy_o,
    output logic        err_o,
    input  logic        err_clr_i
);
    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
    localparam logic [15:0] POLL_LIM   = 16'(POLL_LIMIT);
    localparam logic [7:0]  CTRL_GO    = CTRL_CFG | (8'h01 << CTRL_START_BIT);

    seq_state_e  state_q, state_d;
    logic        cs_q, cs_d, dc_q, dc_d, err_q, err_d, last_q, last_d, pend_q, pend_d;
    logic [7:0]  byte_q, byte_d;
    logic [15:0] cnt_q, cnt_d, poll_q, poll_d, poll_inc;

    logic        txn_en, txn_we, txn_start, txn_done, txn_err, accept;
    logic [31:0] txn_addr, txn_wdata, txn_rdata;
    logic        unused_rdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_INIT;
            cs_q    <= 1'b1;
            dc_q    <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            pend_q  <= 1'b0;
            byte_q  <= '0;
            cnt_q   <= '0;
            poll_q  <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            dc_q    <= dc_d;
            err_q   <= err_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
            poll_q  <= poll_d;
        end
    end

    assign poll_inc = poll_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        cs_d        = cs_q;
        dc_d        = dc_q;
        err_d       = err_q;
        last_d      = last_q;
        byte_d      = byte_q;
        cnt_d       = cnt_q;
        poll_d      = poll_q;
        cmd_ready_o = 1'b0;
        txn_en      = 1'b0;
        txn_we      = 1'b1;
        txn_addr    = SPI_BASE_ADDR + REG_CTRL;
        txn_wdata   = '0;
        case (state_q)
            ST_INIT: begin
                txn_en    = 1'b1;
                txn_addr  = SPI_BASE_ADDR + REG_CLK_DIV;
                txn_wdata = {24'h0, CLK_DIV};
                if (txn_done) state_d = ST_IDLE;
            end
            ST_IDLE: cmd_ready_o = !err_q;
            ST_CS_SETUP: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q >= SETUP_LAST) state_d = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                txn_en    = 1'b1;
                txn_addr  = SPI_BASE_ADDR + REG_DATA_TX;
                txn_wdata = {24'h0, byte_q};
                if (txn_done) state_d = ST_WR_CTRL;
            end
            ST_WR_CTRL: begin
                txn_en    = 1'b1;
                txn_wdata = {24'h0, CTRL_GO};
                if (txn_done) state_d = ST_POLL_CTRL;
            end
            ST_POLL_CTRL: begin
                txn_en = 1'b1;
                txn_we = 1'b0;
                if (txn_done) begin
                    poll_d = poll_inc;
                    if (!txn_rdata[CTRL_START_BIT]) state_d = ST_POLL_STAT;
                    else if (poll_inc >= POLL_LIM)  state_d = ST_ERROR;
                end
            end
            ST_POLL_STAT: begin
                txn_en   = 1'b1;
                txn_we   = 1'b0;
                txn_addr = SPI_BASE_ADDR + REG_STATUS;
                if (txn_done) begin
                    poll_d = poll_inc;
                    if (!txn_rdata[STAT_BUSY_BIT]) begin
                        cnt_d = '0;
                        if (last_q) begin
                            state_d = ST_CS_HOLD;
                        end else begin
                            // cs_no stays low: the frame continues with the next byte
                            state_d     = ST_IDLE;
                            cmd_ready_o = !txn_err;
                        end
                    end else if (poll_inc >= POLL_LIM) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_CS_HOLD: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q >= HOLD_LAST) begin
                    cs_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: if (err_clr_i) begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase

        accept = cmd_ready_o && cmd_valid_i;
        if (accept) begin
            byte_d = cmd_byte_i;
            dc_d   = cmd_dc_i;
            last_d = cmd_last_i;
            poll_d = '0;
            cnt_d  = '0;
            if (state_q == ST_IDLE && cs_q) begin
                cs_d    = 1'b0;
                state_d = ST_CS_SETUP;
            end else begin
                state_d = ST_WR_DATA;
            end
        end

        if (txn_err) state_d = ST_ERROR;
        if (state_d == ST_ERROR && state_q != ST_ERROR) begin
            err_d = 1'b1;
            cs_d  = 1'b1;
        end
    end

    assign txn_start = txn_en && !pend_q;
    assign pend_d    = txn_start ? 1'b1 : (txn_done ? 1'b0 : pend_q);

    obi_single_master u_master (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (txn_start),
        .we_i        (txn_we),
        .addr_i      (txn_addr),
        .wdata_i     (txn_wdata),
        .done_o      (txn_done),
        .rdata_o     (txn_rdata),
        .err_o       (txn_err),
        .obi_req_o   (obi_req_o),
        .obi_we_o    (obi_we_o),
        .obi_addr_o  (obi_addr_o),
        .obi_wdata_o (obi_wdata_o),
        .obi_gnt_i   (obi_gnt_i),
        .obi_rvalid_i(obi_rvalid_i),
        .obi_rdata_i (obi_rdata_i),
        .obi_err_i   (obi_err_i)
    );

    assign unused_rdata = ^txn_rdata[31:2];
    assign obi_be_o     = 4'b0001;
    assign cs_no        = cs_q;
    assign dc_o         = dc_q;
    assign err_o        = err_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_sequencer.sv
// Scoreboarded bench: expected OBI writes are queued as bytes are offered and
// checked as the slave model grants them; the slave emulates the SPI registers.
module tb_spi_sequencer;
    import obi_spi_pkg::*;

    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0, cmd_dc_i = 1'b0, cmd_last_i = 1'b0, err_clr_i = 1'b0;
    logic [7:0]  cmd_byte_i = '0;
    logic        cmd_ready_o, obi_req_o, obi_we_o, cs_no, dc_o, busy_o, err_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_addr_o, obi_wdata_o;
    logic        obi_gnt_i = 1'b0, obi_rvalid_i = 1'b0, obi_err_i = 1'b0;
    logic [31:0] obi_rdata_i = '0;

    always #5 clk_i = ~clk_i;

    spi_sequencer dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_byte_i(cmd_byte_i),
        .cmd_dc_i(cmd_dc_i), .cmd_last_i(cmd_last_i),
        .obi_req_o(obi_req_o), .obi_we_o(obi_we_o), .obi_be_o(obi_be_o),
        .obi_addr_o(obi_addr_o), .obi_wdata_o(obi_wdata_o), .obi_gnt_i(obi_gnt_i),
        .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
        .cs_no(cs_no), .dc_o(dc_o), .busy_o(busy_o), .err_o(err_o), .err_clr_i(err_clr_i)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        dc;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  n_cmp = 0, n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // slave model state
    int          gnt_wait = 0, wait_cnt = 0, stat_busy_n = 2, stat_cnt = 0, rd_cnt = 0;
    bit          resp_pend = 0, resp_err = 0, inject_err = 0, stat_stuck = 0;
    bit          ctrl_pend = 0, saw_stat = 0, holding = 0;
    logic [31:0] resp_data = '0, hold_addr = '0, hold_wdata = '0;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            obi_gnt_i = 0; obi_rvalid_i = 0; obi_err_i = 0;
            resp_pend = 0; wait_cnt = 0; holding = 0;
        end else begin
            obi_rvalid_i = 0; obi_err_i = 0; obi_rdata_i = '0;
            if (resp_pend) begin
                obi_rvalid_i = 1; obi_rdata_i = resp_data; obi_err_i = resp_err;
                resp_pend = 0;
            end
            if (obi_gnt_i) begin
                obi_gnt_i = 0;
            end else if (obi_req_o) begin
                if (holding) begin
                    chk("hold_addr", obi_addr_o, hold_addr);
                    chk("hold_wdata", obi_wdata_o, hold_wdata);
                end else begin
                    holding = 1; hold_addr = obi_addr_o; hold_wdata = obi_wdata_o;
                end
                if (wait_cnt >= gnt_wait) begin
                    obi_gnt_i = 1; wait_cnt = 0; holding = 0; resp_pend = 1;
                    chk("be", {28'h0, obi_be_o}, 32'h1);
                    if (obi_we_o) begin
                        if (exp_q.size() == 0) chk("wr_unexpected", obi_addr_o, 32'hFFFF_FFFF);
                        else begin
                            e = exp_q.pop_front();
                            chk("wr_addr", obi_addr_o, e.addr);
                            chk("wr_data", obi_wdata_o, e.wdata);
                            if (e.addr == REG_DATA_TX) begin
                                chk("wr_dc", {31'h0, dc_o}, {31'h0, e.dc});
                                chk("wr_cs_low", {31'h0, cs_no}, 32'h0);
                                rd_cnt = 0;
                            end
                        end
                        resp_data = $urandom;
                        resp_err  = inject_err && (obi_addr_o == REG_DATA_TX);
                        if (resp_err) inject_err = 0;
                        if (obi_addr_o == REG_CTRL) begin
                            ctrl_pend = obi_wdata_o[CTRL_START_BIT];
                            stat_cnt  = stat_busy_n;
                        end
                    end else begin
                        rd_cnt++;
                        resp_err = 0;
                        if (obi_addr_o == REG_CTRL) begin
                            resp_data = {30'h0, ctrl_pend, 1'b1};
                            ctrl_pend = 0;
                        end else begin
                            chk("rd_addr", obi_addr_o, REG_STATUS);
                            saw_stat  = 1;
                            resp_data = (stat_stuck || stat_cnt > 0) ? 32'h1 : 32'h0;
                            if (stat_cnt > 0) stat_cnt--;
                        end
                    end
                end else begin
                    wait_cnt++;
                end
            end else if (holding) begin
                chk("hold_req", 32'h0, 32'h1);
                holding = 0;
            end
        end
    end

    int cs_fall = 0, cs_rise = 0;
    bit cs_prev = 1;
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (cs_prev && !cs_no) cs_fall++;
            if (!cs_prev && cs_no) cs_rise++;
        end
        cs_prev = cs_no;
    end

    // 0: not busy, 1: not busy with cs high, 2: err set, 3: STATUS read seen
    task automatic wait_for(input int which, input int budget);
        bit hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk_i);
            case (which)
                0: hit = !busy_o;
                1: hit = !busy_o && cs_no;
                2: hit = err_o;
                default: hit = saw_stat;
            endcase
        end
        if (!hit) chk("timeout", 32'(which), 32'hDEAD);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc, input logic last, input bit push);
        bit took = 0;
        if (push) begin
            exp_q.push_back('{REG_DATA_TX, {24'h0, b}, dc});
            exp_q.push_back('{REG_CTRL, 32'h3, 1'b0});
        end
        cmd_valid_i = 1; cmd_byte_i = b; cmd_dc_i = dc; cmd_last_i = last;
        for (int i = 0; i < 6000 && !took; i++) begin
            #1;
            if (cmd_ready_o) took = 1;
            else @(negedge clk_i);
        end
        if (took) begin
            @(posedge clk_i);
            @(negedge clk_i);
            chk("acc_dc", {31'h0, dc_o}, {31'h0, dc});
            chk("acc_cs_low", {31'h0, cs_no}, 32'h0);
        end else begin
            chk("accept_timeout", 32'h0, 32'h1);
        end
        cmd_valid_i = 0;
    endtask

    task automatic chk_error_state();
        chk("err_set", {31'h0, err_o}, 32'h1);
        chk("err_cs_high", {31'h0, cs_no}, 32'h1);
        chk("err_ready_low", {31'h0, cmd_ready_o}, 32'h0);
        chk("err_req_low", {31'h0, obi_req_o}, 32'h0);
        err_clr_i = 1;
        @(negedge clk_i);
        err_clr_i = 0;
        chk("clr_err", {31'h0, err_o}, 32'h0);
        chk("clr_idle", {31'h0, busy_o}, 32'h0);
        chk("clr_ready", {31'h0, cmd_ready_o}, 32'h1);
    endtask

    int f0, r0;
    initial begin
        exp_q.push_back('{REG_CLK_DIV, 32'h1, 1'b0});
        repeat (3) @(negedge clk_i);
        chk("rst_cs", {31'h0, cs_no}, 32'h1);
        chk("rst_busy", {31'h0, busy_o}, 32'h1);
        chk("rst_ready", {31'h0, cmd_ready_o}, 32'h0);
        chk("rst_req", {31'h0, obi_req_o}, 32'h0);
        chk("rst_we", {31'h0, obi_we_o}, 32'h0);
        chk("rst_be", {28'h0, obi_be_o}, 32'h1);
        chk("rst_addr", obi_addr_o, 32'h0);
        chk("rst_wdata", obi_wdata_o, 32'h0);
        chk("rst_dc", {31'h0, dc_o}, 32'h0);
        chk("rst_err", {31'h0, err_o}, 32'h0);
        rst_ni = 1;
        wait_for(0, 100);
        chk("init_ready", {31'h0, cmd_ready_o}, 32'h1);
        chk("init_sb", 32'(exp_q.size()), 32'h0);

        // single terminal byte
        f0 = cs_fall;
        send_byte(8'hA5, 1'b1, 1'b1, 1);
        wait_for(1, 500);
        chk("single_cs_high", {31'h0, cs_no}, 32'h1);
        chk("single_sb", 32'(exp_q.size()), 32'h0);
        chk("single_fall", 32'(cs_fall - f0), 32'h1);

        // three bytes back-to-back
        f0 = cs_fall; r0 = cs_rise;
        send_byte(8'h11, 1'b0, 1'b0, 1);
        send_byte(8'h22, 1'b1, 1'b0, 1);
        send_byte(8'h33, 1'b0, 1'b1, 1);
        wait_for(1, 1000);
        chk("b2b_fall_once", 32'(cs_fall - f0), 32'h1);
        chk("b2b_rise_once", 32'(cs_rise - r0), 32'h1);
        chk("b2b_sb", 32'(exp_q.size()), 32'h0);

        // gap inside a frame: cs stays low, no second setup
        f0 = cs_fall;
        send_byte(8'h44, 1'b0, 1'b0, 1);
        wait_for(0, 500);
        chk("gap_cs_low", {31'h0, cs_no}, 32'h0);
        chk("gap_ready", {31'h0, cmd_ready_o}, 32'h1);
        send_byte(8'h55, 1'b1, 1'b1, 1);
        wait_for(1, 500);
        chk("gap_fall_once", 32'(cs_fall - f0), 32'h1);

        // slow grant
        gnt_wait = 5;
        send_byte(8'h5A, 1'b1, 1'b1, 1);
        wait_for(1, 1000);
        gnt_wait = 0;
        chk("slow_sb", 32'(exp_q.size()), 32'h0);

        // bus error on DATA_TX write
        inject_err = 1;
        exp_q.push_back('{REG_DATA_TX, 32'h0000_0096, 1'b0});
        send_byte(8'h96, 1'b0, 1'b1, 0);
        wait_for(2, 500);
        chk("buserr_sb", 32'(exp_q.size()), 32'h0);
        chk_error_state();

        // STATUS stuck busy: poll limit
        stat_stuck = 1;
        send_byte(8'hC3, 1'b0, 1'b1, 1);
        wait_for(2, 6000);
        chk("poll_reads", 32'(rd_cnt), 32'd1024);
        chk_error_state();
        stat_stuck = 0;

        // reset during STATUS polling
        stat_busy_n = 20; saw_stat = 0;
        send_byte(8'h7E, 1'b1, 1'b1, 1);
        wait_for(3, 500);
        rst_ni = 0;
        @(negedge clk_i);
        chk("mid_rst_cs", {31'h0, cs_no}, 32'h1);
        chk("mid_rst_busy", {31'h0, busy_o}, 32'h1);
        chk("mid_rst_req", {31'h0, obi_req_o}, 32'h0);
        chk("mid_rst_sb", 32'(exp_q.size()), 32'h0);
        stat_busy_n = 2;
        exp_q.push_back('{REG_CLK_DIV, 32'h1, 1'b0});
        @(negedge clk_i);
        rst_ni = 1;
        wait_for(0, 100);
        chk("rerun_init_sb", 32'(exp_q.size()), 32'h0);
        chk("rerun_ready", {31'h0, cmd_ready_o}, 32'h1);
        chk("rerun_cs", {31'h0, cs_no}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
